mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, number of WAIT-state cycles before a load is abandoned as a bus error.
REQ-002 The module SHALL have one clock and an asynchronous, active-low reset, with ports named as the codebase does:
  clk  in  1  system clock, all state on rising edge
  reset  in  1  asynchronous active-low reset
  req_valid  in  1  M-stage memory operation present
  req_we  in  1  1=store, 0=load
  req_op  in  2  width: 00 word, 01 half, 10 byte, 11 illegal
  req_addr  in  32  byte address
  req_wdata  in  32  store data, right-aligned
  req_ready  out  1  controller idle, request accepted this cycle
  stall  out  1  freeze pipeline stages up to and including M
  bus_req  out  1  bus request
  bus_we  out  1  bus write
  bus_addr  out  32  word address, {req_addr[31:2],2'b00}
  bus_byteen  out  4  byte enables
  bus_wdata  out  32  lane-replicated store data
  bus_gnt  in  1  bus accepts request
  bus_rvalid  in  1  read data valid
  bus_rdata  in  32  read data
  rsp_valid  out  1  one-cycle completion pulse
  rsp_rdata  out  32  raw word for load-extension stage
  rsp_byte_addr  out  2  req_addr[1:0] of the completed load
  rsp_load_op  out  2  req_op of the completed load
  bus_err  out  1  completion was a timeout
  exc_adel  out  1  load address exception pulse
  exc_ades  out  1  store address exception pulse

Function
REQ-003 The FSM SHALL have the states IDLE, REQ, WAIT and RESP, and req_ready SHALL be asserted exactly in IDLE.
REQ-004 Legality: word with addr[1:0]!=0, half with addr[0]=1, or op=11 SHALL be illegal.
REQ-005 In IDLE with req_valid and illegal: pulse exc_adel (load) or exc_ades (store) for 1 cycle, no bus activity, stay IDLE.
REQ-006 In IDLE with req_valid and legal: latch we/op/addr/wdata, go to REQ next cycle.
REQ-007 Byte enables: word 1111; half addr[1]?1100:0011; byte 0001<<addr[1:0].
REQ-008 Store data: word as-is; half {2{wdata[15:0]}}; byte {4{wdata[7:0]}}.
REQ-009 In REQ, bus_req SHALL be held with stable addr/we/byteen/wdata until bus_gnt is high; on gnt a store goes to RESP and a load goes to WAIT.
REQ-010 In WAIT: bus_rvalid SHALL capture bus_rdata into rsp_rdata and go to RESP; bus_rvalid outside WAIT SHALL be ignored.
REQ-011 A WAIT cycle counter SHALL clear on WAIT entry; after TIMEOUT_CYCLES cycles without rvalid, set rsp_rdata=0, assert bus_err, and go to RESP.
REQ-012 In RESP: rsp_valid=1 for exactly 1 cycle, then IDLE; bus_err SHALL be high only in this RESP cycle.
REQ-013 rsp_rdata, rsp_byte_addr and rsp_load_op SHALL hold their values until the next load completion; a store SHALL NOT alter them.
REQ-014 stall = (IDLE & req_valid & legal) | REQ | WAIT; stall SHALL be low in RESP.
REQ-015 Minimum load latency: accept cycle N, gnt in N+1, rvalid in N+2, rsp_valid in N+3; minimum store latency: rsp_valid in N+2.
REQ-016 bus_req SHALL be 0 outside REQ; bus_we, bus_byteen and bus_wdata SHALL be 0 when bus_req=0.

Reset
REQ-017 reset low SHALL immediately force IDLE and zero the counter and every output except req_ready, which SHALL be 1.
REQ-018 Reset mid-transaction SHALL abandon it with no rsp_valid, and a late rvalid after reset release SHALL be ignored.

Verification
REQ-019 Byte store, addr 0x1003, wdata 0x000000AB, gnt on first REQ cycle -> bus_byteen=1000, bus_wdata=0xABABABAB, bus_addr=0x1000, rsp_valid at N+2.
REQ-020 Half load, addr 0x2002, gnt delayed 3 cycles, rvalid rdata 0x8001_7FFF -> rsp_rdata=0x80017FFF, rsp_byte_addr=10, rsp_load_op=01, stall high until the RESP cycle.
REQ-021 Word load, addr 0x3001 -> exc_adel one cycle, bus_req never asserted, state remains IDLE; byte store with op=11 -> exc_ades.
REQ-022 Load with rvalid withheld, TIMEOUT_CYCLES=4 -> rsp_valid with bus_err=1 and rsp_rdata=0 after 4 WAIT cycles.
REQ-023 Reset asserted during WAIT, rvalid pulsed 1 cycle after release -> all outputs zero except req_ready=1, no rsp_valid.
REQ-024 Back-to-back legal requests with req_valid held -> second request accepted on the cycle after RESP, no request lost or duplicated.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// M-stage memory access controller: qualifies and aligns loads/stores, runs the bus
// handshake and returns the raw load word with a one-cycle completion pulse.
//
// state | meaning
// IDLE  | ready for a new request; illegal requests raise an address exception here
// REQ   | bus_req held with latched address/data until bus_gnt
// WAIT  | load granted, waiting for bus_rvalid or the timeout
// RESP  | one-cycle completion (rsp_valid), bus_err marks a timed-out load
module mem_access_ctrl #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        stall,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_byteen,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_byte_addr,
    output logic [1:0]  rsp_load_op,
    output logic        bus_err,
    output logic        exc_adel,
    output logic        exc_ades
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic [31:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]    rsp_byte_addr_q, rsp_byte_addr_d;
    logic [1:0]    rsp_load_op_q, rsp_load_op_d;

    logic          we_q, we_d;
    logic [1:0]    op_q, op_d;
    logic [31:0]   addr_q, addr_d;
    logic [3:0]    byteen_q, byteen_d;
    logic [31:0]   wdata_q, wdata_d;

    logic          legal;
    logic          is_idle;
    logic [3:0]    byteen_new;
    logic [31:0]   wdata_new;

    always_comb begin
        legal      = 1'b0;
        byteen_new = 4'b0000;
        wdata_new  = 32'h0;
        case (req_op)
            2'b00: begin
                legal      = (req_addr[1:0] == 2'b00);
                byteen_new = 4'b1111;
                wdata_new  = req_wdata;
            end
            2'b01: begin
                legal      = ~req_addr[0];
                byteen_new = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_new  = {2{req_wdata[15:0]}};
            end
            2'b10: begin
                legal      = 1'b1;
                byteen_new = 4'b0001 << req_addr[1:0];
                wdata_new  = {4{req_wdata[7:0]}};
            end
            default: begin
                legal      = 1'b0;
                byteen_new = 4'b0000;
                wdata_new  = 32'h0;
            end
        endcase
    end

    assign is_idle = (state_q == S_IDLE);

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        err_d           = err_q;
        rsp_rdata_d     = rsp_rdata_q;
        rsp_byte_addr_d = rsp_byte_addr_q;
        rsp_load_op_d   = rsp_load_op_q;
        we_d            = we_q;
        op_d            = op_q;
        addr_d          = addr_q;
        byteen_d        = byteen_q;
        wdata_d         = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid && legal) begin
                    we_d     = req_we;
                    op_d     = req_op;
                    addr_d   = req_addr;
                    byteen_d = byteen_new;
                    wdata_d  = wdata_new;
                    state_d  = S_REQ;
                end
            end
            S_REQ: begin
                if (bus_gnt) begin
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = we_q ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus_rvalid) begin
                    rsp_rdata_d     = bus_rdata;
                    rsp_byte_addr_d = addr_q[1:0];
                    rsp_load_op_d   = op_q;
                    err_d           = 1'b0;
                    state_d         = S_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    // abandoned load completes with a zero word flagged as a bus error
                    rsp_rdata_d     = 32'h0;
                    rsp_byte_addr_d = addr_q[1:0];
                    rsp_load_op_d   = op_q;
                    err_d           = 1'b1;
                    state_d         = S_RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RESP: begin
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= S_IDLE;
            cnt_q           <= '0;
            err_q           <= 1'b0;
            rsp_rdata_q     <= 32'h0;
            rsp_byte_addr_q <= 2'b00;
            rsp_load_op_q   <= 2'b00;
            we_q            <= 1'b0;
            op_q            <= 2'b00;
            addr_q          <= 32'h0;
            byteen_q        <= 4'b0000;
            wdata_q         <= 32'h0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            err_q           <= err_d;
            rsp_rdata_q     <= rsp_rdata_d;
            rsp_byte_addr_q <= rsp_byte_addr_d;
            rsp_load_op_q   <= rsp_load_op_d;
            we_q            <= we_d;
            op_q            <= op_d;
            addr_q          <= addr_d;
            byteen_q        <= byteen_d;
            wdata_q         <= wdata_d;
        end
    end

    assign req_ready     = is_idle;
    assign stall         = (is_idle & req_valid & legal) | (state_q == S_REQ) | (state_q == S_WAIT);
    assign exc_adel      = is_idle & req_valid & ~legal & ~req_we;
    assign exc_ades      = is_idle & req_valid & ~legal & req_we;

    // bus side is fully quiet whenever no request is outstanding
    assign bus_req       = (state_q == S_REQ);
    assign bus_we        = bus_req & we_q;
    assign bus_addr      = bus_req ? {addr_q[31:2], 2'b00} : 32'h0;
    assign bus_byteen    = bus_req ? byteen_q : 4'b0000;
    assign bus_wdata     = bus_req ? wdata_q : 32'h0;

    assign rsp_valid     = (state_q == S_RESP);
    assign bus_err       = rsp_valid & err_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_byte_addr = rsp_byte_addr_q;
    assign rsp_load_op   = rsp_load_op_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed corner cases plus randomized transactions checked
// against a transaction-level model of alignment, latency and load-result hold.
module tb_mem_access_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_we;
    logic [1:0]  req_op;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, stall;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_byteen;
    logic [31:0] bus_wdata;
    logic        bus_gnt, bus_rvalid;
    logic [31:0] bus_rdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_byte_addr, rsp_load_op;
    logic        bus_err, exc_adel, exc_ades;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] m_rdata;
    logic [1:0]  m_ba, m_lop;

    always #5 clk = ~clk;

    mem_access_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_we(req_we), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .stall(stall),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_byteen(bus_byteen), .bus_wdata(bus_wdata),
        .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_byte_addr(rsp_byte_addr), .rsp_load_op(rsp_load_op),
        .bus_err(bus_err), .exc_adel(exc_adel), .exc_ades(exc_ades)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic is_legal(input logic [1:0] op, input logic [31:0] a);
        if (op == 2'd0) return (a % 4) == 0;
        if (op == 2'd1) return (a % 2) == 0;
        return op == 2'd2;
    endfunction

    function automatic logic [3:0] exp_be(input logic [1:0] op, input logic [31:0] a);
        logic [3:0] half_mask;
        logic [3:0] byte_mask;
        half_mask = 4'h3;
        byte_mask = 4'h1;
        if (op == 2'd0) return 4'hF;
        if (op == 2'd1) return half_mask << a[1:0];
        return byte_mask << a[1:0];
    endfunction

    function automatic logic [31:0] exp_wd(input logic [1:0] op, input logic [31:0] d);
        if (op == 2'd0) return d;
        if (op == 2'd1) return (d & 32'h0000_FFFF) * 32'h0001_0001;
        return (d & 32'h0000_00FF) * 32'h0101_0101;
    endfunction

    task automatic chk_held(input string tag);
        chk({tag, "_rsp_rdata"}, rsp_rdata, m_rdata);
        chk({tag, "_rsp_byte_addr"}, {30'h0, rsp_byte_addr}, {30'h0, m_ba});
        chk({tag, "_rsp_load_op"}, {30'h0, rsp_load_op}, {30'h0, m_lop});
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_req_ready"}, req_ready, 1);
        chk({tag, "_stall"}, stall, 0);
        chk({tag, "_bus_req"}, bus_req, 0);
        chk({tag, "_bus_we"}, bus_we, 0);
        chk({tag, "_bus_addr"}, bus_addr, 0);
        chk({tag, "_bus_byteen"}, bus_byteen, 0);
        chk({tag, "_bus_wdata"}, bus_wdata, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_bus_err"}, bus_err, 0);
        chk({tag, "_exc_adel"}, exc_adel, 0);
        chk({tag, "_exc_ades"}, exc_ades, 0);
        chk_held(tag);
    endtask

    // One full transaction; rdly >= TO withholds rvalid so the load times out.
    task automatic txn(input logic we, input logic [1:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata, input int gdly, input int rdly,
                       input logic [31:0] rdata);
        logic legal;
        logic timeout;
        legal   = is_legal(op, addr);
        timeout = !we && (rdly >= TO);
        req_valid = 1'b1; req_we = we; req_op = op; req_addr = addr; req_wdata = wdata;
        #3;
        chk("accept_ready", req_ready, 1);
        chk("accept_stall", stall, legal);
        chk("accept_exc_adel", exc_adel, !legal && !we);
        chk("accept_exc_ades", exc_ades, !legal && we);
        chk("accept_bus_req", bus_req, 0);
        step();
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
        if (!legal) begin
            #3;
            chk_quiet("illegal_after");
            step();
            return;
        end
        for (int i = 0; i <= gdly; i++) begin
            bus_gnt = (i == gdly);
            bus_rvalid = 1'($urandom_range(0, 1));
            bus_rdata = $urandom;
            #3;
            chk("req_bus_req", bus_req, 1);
            chk("req_bus_addr", bus_addr, addr & 32'hFFFF_FFFC);
            chk("req_bus_we", bus_we, we);
            chk("req_bus_byteen", bus_byteen, exp_be(op, addr));
            chk("req_bus_wdata", bus_wdata, exp_wd(op, wdata));
            chk("req_stall", stall, 1);
            chk("req_ready", req_ready, 0);
            chk("req_rsp_valid", rsp_valid, 0);
            step();
        end
        bus_gnt = 1'b0; bus_rvalid = 1'b0;
        if (!we) begin
            for (int i = 0; i < TO; i++) begin
                bus_rvalid = (i == rdly);
                bus_rdata = (i == rdly) ? rdata : $urandom;
                #3;
                chk("wait_stall", stall, 1);
                chk("wait_bus_req", bus_req, 0);
                chk("wait_bus_byteen", bus_byteen, 0);
                chk("wait_rsp_valid", rsp_valid, 0);
                step();
                if (i == rdly) break;
            end
            bus_rvalid = 1'b0;
            m_rdata = timeout ? 32'h0 : rdata;
            m_ba    = addr[1:0];
            m_lop   = op;
        end
        #3;
        chk("resp_rsp_valid", rsp_valid, 1);
        chk("resp_bus_err", bus_err, timeout);
        chk("resp_stall", stall, 0);
        chk("resp_ready", req_ready, 0);
        chk("resp_bus_req", bus_req, 0);
        chk_held("resp");
        step();
        #3;
        chk("post_ready", req_ready, 1);
        chk("post_rsp_valid", rsp_valid, 0);
        chk("post_bus_err", bus_err, 0);
        step();
    endtask

    initial begin
        reset = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_op = 2'b00; req_addr = 32'h0; req_wdata = 32'h0;
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
        m_rdata = 32'h0; m_ba = 2'b00; m_lop = 2'b00;
        #3;
        chk_quiet("reset");
        step();
        step();
        reset = 1'b1;
        step();

        // byte store, lane 3, immediate grant
        txn(1'b1, 2'b10, 32'h0000_1003, 32'h0000_00AB, 0, 0, 32'h0);
        // half load in the upper half, grant delayed three cycles
        txn(1'b0, 2'b01, 32'h0000_2002, $urandom, 3, 0, 32'h8001_7FFF);
        // misaligned word load and op=11 store both trap
        txn(1'b0, 2'b00, 32'h0000_3001, 32'h0, 0, 0, 32'h0);
        txn(1'b1, 2'b11, 32'h0000_3000, 32'h1234_5678, 0, 0, 32'h0);
        // store leaves load result untouched, then a timed-out load
        txn(1'b1, 2'b00, 32'h0000_4000, 32'hCAFE_F00D, 1, 0, 32'h0);
        txn(1'b0, 2'b00, 32'h0000_5004, 32'h0, 0, 99, 32'h1111_2222);

        // back-to-back: req_valid held, second request presented right after RESP
        req_valid = 1'b1; req_we = 1'b1; req_op = 2'b00; req_addr = 32'h100; req_wdata = 32'h5A5A_A5A5;
        #3; chk("b2b_first_stall", stall, 1);
        step();
        bus_gnt = 1'b1;
        #3; chk("b2b_first_bus_addr", bus_addr, 32'h100);
        step();
        bus_gnt = 1'b0;
        #3;
        chk("b2b_first_rsp", rsp_valid, 1);
        chk("b2b_resp_not_ready", req_ready, 0);
        step();
        req_we = 1'b0; req_op = 2'b10; req_addr = 32'h201; req_wdata = 32'h0;
        #3;
        chk("b2b_second_accept", req_ready, 1);
        chk("b2b_second_stall", stall, 1);
        chk("b2b_no_dup_rsp", rsp_valid, 0);
        step();
        bus_gnt = 1'b1;
        #3;
        chk("b2b_second_bus_req", bus_req, 1);
        chk("b2b_second_bus_addr", bus_addr, 32'h200);
        chk("b2b_second_byteen", bus_byteen, 4'b0010);
        step();
        bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h0BAD_BEEF;
        step();
        bus_rvalid = 1'b0;
        m_rdata = 32'h0BAD_BEEF; m_ba = 2'b01; m_lop = 2'b10;
        #3;
        chk("b2b_second_rsp", rsp_valid, 1);
        chk_held("b2b_second");
        step();
        req_valid = 1'b0;
        #3;
        chk("b2b_no_third_rsp", rsp_valid, 0);
        chk("b2b_idle_bus_req", bus_req, 0);
        step();

        // reset while waiting for read data, then a late rvalid
        req_valid = 1'b1; req_we = 1'b0; req_op = 2'b00; req_addr = 32'h40;
        step();
        req_valid = 1'b0; bus_gnt = 1'b1;
        step();
        bus_gnt = 1'b0;
        #1;
        chk("rst_wait_stall", stall, 1);
        reset = 1'b0;
        m_rdata = 32'h0; m_ba = 2'b00; m_lop = 2'b00;
        #1;
        chk_quiet("rst_mid");
        step();
        reset = 1'b1;
        step();
        bus_rvalid = 1'b1; bus_rdata = 32'hDEAD_BEEF;
        #3;
        chk("rst_late_rvalid_rsp", rsp_valid, 0);
        step();
        bus_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #3;
            chk_quiet("rst_after");
            step();
        end

        // randomized transactions
        for (int n = 0; n < 60; n++) begin
            logic        r_we;
            logic [1:0]  r_op;
            logic [31:0] r_addr;
            r_we   = 1'($urandom_range(0, 1));
            r_op   = 2'($urandom_range(0, 3));
            r_addr = $urandom;
            if ($urandom_range(0, 2) != 0)
                r_addr = (r_op == 2'd0) ? (r_addr & 32'hFFFF_FFFC) :
                         (r_op == 2'd1) ? (r_addr & 32'hFFFF_FFFE) : r_addr;
            txn(r_we, r_op, r_addr, $urandom, $urandom_range(0, 3), $urandom_range(0, 5), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
